// File: rtl/otus_binarize_if.sv
// Pixel/threshold bus for otus_binarize. The slave side is the binarizer.
// The master side is the video source and the threshold DSP.
interface otus_binarize_if;
  logic       thr_vld;
  logic [7:0] thr;
  logic [7:0] iGray_orig;
  logic       hs;
  logic       vs;
  logic       de;
  logic [7:0] oBin;
  logic       o_hs;
  logic       o_vs;
  logic       o_de;
  logic [7:0] thr_active;
  logic       thr_stale;

  modport master (
    output thr_vld, thr, iGray_orig, hs, vs, de,
    input  oBin, o_hs, o_vs, o_de, thr_active, thr_stale
  );

  modport slave (
    input  thr_vld, thr, iGray_orig, hs, vs, de,
    output oBin, o_hs, o_vs, o_de, thr_active, thr_stale
  );
endinterface

// File: rtl/otus_binarize.sv
// otus_binarize: applies the per-frame Otsu threshold to a gray stream, 2-cycle latency, no backpressure.
// Defining OTUS_BIN_INVERT_EN inverts the mask polarity (dark foreground).
module otus_binarize #(
  parameter logic [7:0]  DEFAULT_THR  = 8'd128,
  parameter int unsigned STALE_FRAMES = 4
) (
  input logic            clock,
  input logic            rst_n,
  otus_binarize_if.slave bus
);

  localparam logic [3:0] STALE_LIM = 4'(STALE_FRAMES);

  typedef enum logic [1:0] {INIT, FRESH, STALE} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] stale_cnt;
  logic [3:0] cnt_d;

  logic       prev_vs;
  logic       fs;
  logic       load;
  logic [7:0] thr_active;
  logic [7:0] thr_next;
  logic [7:0] pend_thr;
  logic       pend_flag;

  logic       hit;
  logic [7:0] bin_s1;
  logic       hs_s1;
  logic       vs_s1;
  logic       de_s1;
  logic [7:0] bin_s2;
  logic       hs_s2;
  logic       vs_s2;
  logic       de_s2;

  assign fs   = bus.vs & ~prev_vs;
  assign load = fs & (bus.thr_vld | pend_flag);

  // A pulse landing on the FS cycle beats any older pending value.
  always_comb begin
    thr_next = thr_active;
    if (fs) begin
      if (bus.thr_vld)
        thr_next = bus.thr;
      else if (pend_flag)
        thr_next = pend_thr;
    end
  end

`ifdef OTUS_BIN_INVERT_EN
  assign hit = (bus.iGray_orig <= thr_next);
`else
  assign hit = (bus.iGray_orig > thr_next);
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_vs    <= 1'b0;
      thr_active <= DEFAULT_THR;
      pend_thr   <= 8'h00;
      pend_flag  <= 1'b0;
    end else begin
      prev_vs    <= bus.vs;
      thr_active <= thr_next;
      if (fs) begin
        pend_flag <= 1'b0;
      end else if (bus.thr_vld) begin
        pend_thr  <= bus.thr;
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bin_s1 <= 8'h00;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      de_s1  <= 1'b0;
      bin_s2 <= 8'h00;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
      de_s2  <= 1'b0;
    end else begin
      bin_s1 <= (bus.de && hit) ? 8'hFF : 8'h00;
      hs_s1  <= bus.hs;
      vs_s1  <= bus.vs;
      de_s1  <= bus.de;
      bin_s2 <= de_s1 ? bin_s1 : 8'h00;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
      de_s2  <= de_s1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      stale_cnt <= 4'd0;
    end else begin
      state_q   <= state_d;
      stale_cnt <= cnt_d;
    end
  end

  // INIT only leaves on a load, so it can never age into STALE.
  always_comb begin
    state_d = state_q;
    cnt_d   = stale_cnt;
    case (state_q)
      INIT: begin
        if (load) begin
          state_d = FRESH;
          cnt_d   = 4'd0;
        end
      end
      FRESH, STALE: begin
        if (load) begin
          state_d = FRESH;
          cnt_d   = 4'd0;
        end else if (fs) begin
          if (stale_cnt != 4'hF)
            cnt_d = stale_cnt + 4'd1;
          if (cnt_d >= STALE_LIM)
            state_d = STALE;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign bus.oBin       = bin_s2;
  assign bus.o_hs       = hs_s2;
  assign bus.o_vs       = vs_s2;
  assign bus.o_de       = de_s2;
  assign bus.thr_active = thr_active;
  assign bus.thr_stale  = (state_q == STALE);

endmodule

// File: tb/tb_otus_binarize.sv
// Directed bench for otus_binarize: default threshold, frame-boundary swaps, staleness, edge thresholds, reset.
module tb_otus_binarize;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  otus_binarize_if bus();

  otus_binarize #(.DEFAULT_THR(8'd128), .STALE_FRAMES(4)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_bin(input int g, input int t);
`ifdef OTUS_BIN_INVERT_EN
    return (g <= t) ? 8'hFF : 8'h00;
`else
    return (g > t) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic d, input int g, input logic tv, input int t);
    bus.vs         = v;
    bus.hs         = v;
    bus.de         = d;
    bus.iGray_orig = 8'(g);
    bus.thr_vld    = tv;
    bus.thr        = 8'(t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 0, 1'b0, 0);
      tick();
    end
  endtask

  // One FS cycle; thr_active is observable right after it.
  task automatic fs_cycle(input logic tv, input int t, input logic d, input int g);
    drive(1'b1, d, g, tv, t);
    tick();
  endtask

  // FS cycle plus one idle: the FS-cycle pixel is then on the outputs.
  task automatic frame_start(input logic tv, input int t, input logic d, input int g);
    fs_cycle(tv, t, d, g);
    idle(1);
  endtask

  task automatic pulse_thr(input int t);
    drive(1'b0, 1'b0, 0, 1'b1, t);
    tick();
    drive(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // Stream pixels first..last; each result appears two edges after it was driven.
  task automatic run_pixels(input int first, input int last, input int t, input string tag);
    logic [7:0] e;
    for (int p = first; p <= last; p++) begin
      drive(1'b0, 1'b1, p, 1'b0, 0);
      tick();
      vectors++;
      if (p == first) begin
        if (bus.o_de !== 1'b0) begin
          errors++;
          $display("FAIL %s latency: o_de=%b required 0 one edge after first pixel", tag, bus.o_de);
        end
      end else begin
        e = exp_bin(p - 1, t);
        if (bus.oBin !== e || bus.o_de !== 1'b1) begin
          errors++;
          $display("FAIL %s pix %0d thr %0d: oBin=%h o_de=%b required %h/1", tag, p - 1, t, bus.oBin, bus.o_de, e);
        end
      end
    end
    drive(1'b0, 1'b0, 255, 1'b0, 0);
    tick();
    e = exp_bin(last, t);
    vectors++;
    if (bus.oBin !== e) begin
      errors++;
      $display("FAIL %s pix %0d thr %0d: oBin=%h required %h", tag, last, t, bus.oBin, e);
    end
    tick();
    vectors++;
    if (bus.oBin !== 8'h00 || bus.o_de !== 1'b0) begin
      errors++;
      $display("FAIL %s blank: oBin=%h o_de=%b required 00/0", tag, bus.oBin, bus.o_de);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 200, 1'b0, 0);
    tick();
    tick();
    vectors++;
    if (bus.oBin !== 8'h00 || bus.o_hs !== 1'b0 || bus.o_vs !== 1'b0 || bus.o_de !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: oBin=%h hs=%b vs=%b de=%b required all 0", bus.oBin, bus.o_hs, bus.o_vs, bus.o_de);
    end
    vectors++;
    if (bus.thr_active !== 8'd128 || bus.thr_stale !== 1'b0) begin
      errors++;
      $display("FAIL reset thr: thr_active=%0d stale=%b required 128/0", bus.thr_active, bus.thr_stale);
    end
    idle(1);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_default_thr;
    frame_start(1'b0, 0, 1'b0, 0);
    vectors++;
    if (bus.o_vs !== 1'b1 || bus.o_hs !== 1'b1) begin
      errors++;
      $display("FAIL sync delay: o_vs=%b o_hs=%b required 1/1", bus.o_vs, bus.o_hs);
    end
    run_pixels(0, 255, 128, "default");
    for (int k = 0; k < 5; k++) frame_start(1'b0, 0, 1'b0, 0);
    vectors++;
    if (bus.thr_active !== 8'd128 || bus.thr_stale !== 1'b0) begin
      errors++;
      $display("FAIL init hold: thr_active=%0d stale=%b required 128/0", bus.thr_active, bus.thr_stale);
    end
  endtask

  task automatic test_midframe_load;
    frame_start(1'b0, 0, 1'b0, 0);
    run_pixels(126, 127, 128, "pre50");
    pulse_thr(50);
    vectors++;
    if (bus.thr_active !== 8'd128) begin
      errors++;
      $display("FAIL midframe hold: thr_active=%0d required 128", bus.thr_active);
    end
    run_pixels(127, 130, 128, "same_frame");
    fs_cycle(1'b0, 0, 1'b0, 0);
    vectors++;
    if (bus.thr_active !== 8'd50) begin
      errors++;
      $display("FAIL swap at FS: thr_active=%0d required 50", bus.thr_active);
    end
    idle(1);
    run_pixels(49, 52, 50, "thr50");
  endtask

  task automatic test_fs_collision;
    pulse_thr(10);
    fs_cycle(1'b1, 200, 1'b1, 150);
    vectors++;
    if (bus.thr_active !== 8'd200 || dut.pend_flag !== 1'b0) begin
      errors++;
      $display("FAIL fs collision: thr_active=%0d pend=%b required 200/0", bus.thr_active, dut.pend_flag);
    end
    idle(1);
    vectors++;
    if (bus.oBin !== exp_bin(150, 200)) begin
      errors++;
      $display("FAIL fs pixel: oBin=%h required %h", bus.oBin, exp_bin(150, 200));
    end
    run_pixels(199, 201, 200, "thr200");
    frame_start(1'b0, 0, 1'b0, 0);
    vectors++;
    if (bus.thr_active !== 8'd200) begin
      errors++;
      $display("FAIL pending discarded: thr_active=%0d required 200", bus.thr_active);
    end
  endtask

  task automatic test_stale;
    frame_start(1'b1, 77, 1'b0, 0);
    vectors++;
    if (bus.thr_active !== 8'd77 || bus.thr_stale !== 1'b0) begin
      errors++;
      $display("FAIL fresh load: thr_active=%0d stale=%b required 77/0", bus.thr_active, bus.thr_stale);
    end
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if (bus.thr_stale !== 1'b0) begin
        errors++;
        $display("FAIL stale early before FS %0d: stale=%b required 0", k, bus.thr_stale);
      end
      fs_cycle(1'b0, 0, 1'b0, 0);
      vectors++;
      if (bus.thr_stale !== (k == 4)) begin
        errors++;
        $display("FAIL stale after FS %0d: stale=%b required %b", k, bus.thr_stale, (k == 4));
      end
      idle(2);
    end
    fs_cycle(1'b1, 90, 1'b0, 0);
    vectors++;
    if (bus.thr_stale !== 1'b0 || bus.thr_active !== 8'd90) begin
      errors++;
      $display("FAIL stale clear: stale=%b thr_active=%0d required 0/90", bus.thr_stale, bus.thr_active);
    end
    idle(1);
  endtask

  task automatic test_edge_thr;
    frame_start(1'b1, 255, 1'b1, 255);
    vectors++;
    if (bus.oBin !== exp_bin(255, 255) || bus.o_vs !== 1'b1) begin
      errors++;
      $display("FAIL thr255 fs pixel: oBin=%h o_vs=%b required %h/1", bus.oBin, bus.o_vs, exp_bin(255, 255));
    end
    run_pixels(0, 3, 255, "thr255_lo");
    run_pixels(252, 255, 255, "thr255_hi");
    frame_start(1'b1, 0, 1'b1, 0);
    vectors++;
    if (bus.oBin !== exp_bin(0, 0)) begin
      errors++;
      $display("FAIL thr0 fs pixel: oBin=%h required %h", bus.oBin, exp_bin(0, 0));
    end
    run_pixels(0, 4, 0, "thr0_lo");
    run_pixels(253, 255, 0, "thr0_hi");
  endtask

  task automatic test_midframe_reset;
    frame_start(1'b1, 0, 1'b0, 0);
    pulse_thr(33);
    drive(1'b0, 1'b1, 200, 1'b0, 0);
    tick();
    tick();
    vectors++;
    if (bus.oBin !== exp_bin(200, 0) || bus.o_de !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset pixel: oBin=%h o_de=%b required %h/1", bus.oBin, bus.o_de, exp_bin(200, 0));
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.oBin !== 8'h00 || bus.o_de !== 1'b0 || bus.thr_active !== 8'd128 || dut.pend_flag !== 1'b0) begin
      errors++;
      $display("FAIL async reset: oBin=%h o_de=%b thr_active=%0d pend=%b required 00/0/128/0",
               bus.oBin, bus.o_de, bus.thr_active, dut.pend_flag);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    frame_start(1'b0, 0, 1'b0, 0);
    vectors++;
    if (bus.thr_active !== 8'd128 || bus.thr_stale !== 1'b0) begin
      errors++;
      $display("FAIL post-reset frame: thr_active=%0d stale=%b required 128/0", bus.thr_active, bus.thr_stale);
    end
    run_pixels(127, 130, 128, "post_reset");
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    test_reset();
    test_default_thr();
    test_midframe_load();
    test_fs_collision();
    test_stale();
    test_edge_thr();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
